mm_result_collector: RTL and testbench

//  Downstream stage of the matrix-multiply core. Captures the core's serial result stream
//  (one signed element per in_valid pulse, row boundaries flagged) into a local result buffer.

---
 rtl/mm_result_collector.sv | 206 ++++++++++++++++++++
 tb/tb_mm_result_collector.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_result_collector.sv
// Collects the matrix-multiply result stream into a local buffer, then drains it with row/col tags.
// Build option: define MM_COLLECT_TRANSPOSE_EN to drain column-major instead of row-major.
module mm_result_collector #(
  parameter int DATA_W  = 12,
  parameter int MAX_DIM = 4,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ovf,
  input  logic              in_last_col,
  input  logic              in_last,
  input  logic [1:0]        in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_ovf,
  output logic              out_last,
  output logic [IDX_W:0]    res_rows,
  output logic [IDX_W:0]    res_cols,
  output logic [1:0]        res_err,
  output logic              drop_err,
  output logic              busy
);

  localparam int DEPTH  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LIN_W  = 2 * IDX_W + 2;
  localparam logic [IDX_W:0]  DIM_MAX  = (IDX_W+1)'(MAX_DIM);
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [DATA_W:0]     mem [DEPTH];
  logic [ADDR_W:0]     wr_ptr_reg;
  logic [IDX_W:0]      col_cnt_reg, rows_cnt_reg, cols_cnt_reg;
  logic                cols_known_reg;
  logic [IDX_W-1:0]    drow_reg, dcol_reg;
  logic                pending_reg;
  logic                out_valid_reg, out_ovf_reg, out_last_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [IDX_W-1:0]    out_row_reg, out_col_reg;
  logic [IDX_W:0]      res_rows_reg, res_cols_reg;
  logic [1:0]          res_err_reg;
  logic                drop_err_reg;

  logic                capturing, is_err, elem_ok, do_write, drop_now, frame_end, drain_last_hs;
  logic [IDX_W:0]      col_here, final_rows, final_cols, drow_p1, dcol_p1;
  logic [LIN_W-1:0]    rd_lin;
  logic [ADDR_W-1:0]   rd_addr;
  logic                elem_last;

  function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] v);
    return (v == DIM_MAX) ? v : v + (IDX_W+1)'(1);
  endfunction

  always_comb begin
    capturing     = in_valid && (state_reg != DRAIN);
    is_err        = capturing && (in_err != 2'b00);
    elem_ok       = capturing && !is_err;
    do_write      = elem_ok && (wr_ptr_reg != PTR_FULL);
    drop_now      = (elem_ok && (wr_ptr_reg == PTR_FULL)) || (in_valid && (state_reg == DRAIN));
    frame_end     = capturing && (in_last || is_err);
    col_here      = sat_inc(col_cnt_reg);
    // Closing element always completes a row, whether or not it carries in_last_col.
    final_rows    = sat_inc(rows_cnt_reg);
    final_cols    = cols_known_reg ? cols_cnt_reg : col_here;
    drain_last_hs = out_valid_reg && out_ready && out_last_reg;
    drow_p1       = {1'b0, drow_reg} + (IDX_W+1)'(1);
    dcol_p1       = {1'b0, dcol_reg} + (IDX_W+1)'(1);
    elem_last     = (drow_p1 == res_rows_reg) && (dcol_p1 == res_cols_reg);
    rd_lin        = LIN_W'(drow_reg) * LIN_W'(res_cols_reg) + LIN_W'(dcol_reg);
    rd_addr       = ADDR_W'(rd_lin);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capturing) state_next = frame_end ? DRAIN : COLLECT;
      COLLECT: if (frame_end) state_next = DRAIN;
      DRAIN:   if (drain_last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg[ADDR_W-1:0]] <= {in_ovf, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      col_cnt_reg    <= '0;
      rows_cnt_reg   <= '0;
      cols_cnt_reg   <= '0;
      cols_known_reg <= 1'b0;
      drow_reg       <= '0;
      dcol_reg       <= '0;
      pending_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ovf_reg    <= 1'b0;
      out_last_reg   <= 1'b0;
      out_row_reg    <= '0;
      out_col_reg    <= '0;
      res_rows_reg   <= '0;
      res_cols_reg   <= '0;
      res_err_reg    <= '0;
      drop_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (capturing && (state_reg == IDLE)) drop_err_reg <= 1'b0;
      if (drop_now) drop_err_reg <= 1'b1;

      if (do_write) wr_ptr_reg <= wr_ptr_reg + (ADDR_W+1)'(1);
      if (elem_ok) begin
        if (in_last_col) begin
          rows_cnt_reg <= sat_inc(rows_cnt_reg);
          col_cnt_reg  <= '0;
          if (!cols_known_reg) begin
            cols_cnt_reg   <= col_here;
            cols_known_reg <= 1'b1;
          end
        end else begin
          col_cnt_reg <= col_here;
        end
      end

      if (frame_end) begin
        wr_ptr_reg     <= '0;
        col_cnt_reg    <= '0;
        rows_cnt_reg   <= '0;
        cols_cnt_reg   <= '0;
        cols_known_reg <= 1'b0;
        drow_reg       <= '0;
        dcol_reg       <= '0;
        pending_reg    <= 1'b1;
        res_err_reg    <= is_err ? in_err : 2'b00;
        res_rows_reg   <= is_err ? '0 : final_rows;
        res_cols_reg   <= is_err ? '0 : final_cols;
      end

      if (state_reg == DRAIN) begin
        if (pending_reg && (!out_valid_reg || out_ready)) begin
          out_valid_reg <= 1'b1;
          if (res_err_reg != 2'b00) begin
            // Error frame drains as a single zero-valued element.
            out_data_reg <= '0;
            out_ovf_reg  <= 1'b0;
            out_row_reg  <= '0;
            out_col_reg  <= '0;
            out_last_reg <= 1'b1;
            pending_reg  <= 1'b0;
          end else begin
            {out_ovf_reg, out_data_reg} <= mem[rd_addr];
            out_row_reg  <= drow_reg;
            out_col_reg  <= dcol_reg;
            out_last_reg <= elem_last;
            if (elem_last) begin
              pending_reg <= 1'b0;
            end else begin
`ifdef MM_COLLECT_TRANSPOSE_EN
              if (drow_p1 == res_rows_reg) begin
                drow_reg <= '0;
                dcol_reg <= dcol_reg + IDX_W'(1);
              end else begin
                drow_reg <= drow_reg + IDX_W'(1);
              end
`else
              if (dcol_p1 == res_cols_reg) begin
                dcol_reg <= '0;
                drow_reg <= drow_reg + IDX_W'(1);
              end else begin
                dcol_reg <= dcol_reg + IDX_W'(1);
              end
`endif
            end
          end
        end else if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_last  = out_last_reg;
  assign res_rows  = res_rows_reg;
  assign res_cols  = res_cols_reg;
  assign res_err   = res_err_reg;
  assign drop_err  = drop_err_reg;
  assign busy      = (state_reg == DRAIN);

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector: frame-level model of the drain order plus literal pins.
module tb_mm_result_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ovf, in_last_col, in_last;
  logic [11:0] in_data;
  logic [1:0]  in_err;
  logic        out_valid, out_ready, out_ovf, out_last;
  logic [11:0] out_data;
  logic [1:0]  out_row, out_col;
  logic [2:0]  res_rows, res_cols;
  logic [1:0]  res_err;
  logic        drop_err, busy;

  always #5 clk = ~clk;

  mm_result_collector dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf),
    .in_last_col(in_last_col), .in_last(in_last), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_ovf(out_ovf), .out_last(out_last),
    .res_rows(res_rows), .res_cols(res_cols), .res_err(res_err),
    .drop_err(drop_err), .busy(busy)
  );

  typedef struct {
    logic [11:0] d;
    logic        o;
    int          r;
    int          c;
    logic        l;
  } item_t;

  item_t       exp_q[$];
  item_t       got_q[$];
  int          total = 0;
  int          bad = 0;
  int          ready_mode = 0;
  logic [11:0] fvals[32];
  logic        fovf[32];
  int          exp_rows, exp_cols;
  int          lit6[6];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Expected drain sequence from the frame the bench sends.
  task automatic model_frame(input int n, input int cpr);
    item_t it;
    int rows, cols;
    rows = (n + cpr - 1) / cpr;
    if (rows > 4) rows = 4;
    cols = (cpr > 4) ? 4 : cpr;
    exp_rows = rows;
    exp_cols = cols;
`ifdef MM_COLLECT_TRANSPOSE_EN
    for (int c = 0; c < cols; c++)
      for (int r = 0; r < rows; r++) begin
`else
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
`endif
        it.d = fvals[r*cols+c];
        it.o = fovf[r*cols+c];
        it.r = r;
        it.c = c;
        it.l = (r == rows-1) && (c == cols-1);
        exp_q.push_back(it);
      end
  endtask

  task automatic send_frame(input int n, input int cpr);
    got_q.delete();
    model_frame(n, cpr);
    for (int i = 0; i < n; i++) begin
      in_valid    = 1'b1;
      in_data     = fvals[i];
      in_ovf      = fovf[i];
      in_last_col = ((i + 1) % cpr) == 0;
      in_last     = (i == n - 1);
      in_err      = 2'b00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_last_col = 1'b0; in_ovf = 1'b0; in_data = '0;
  endtask

  task automatic send_err(input logic [1:0] code);
    item_t it;
    got_q.delete();
    it.d = '0; it.o = 1'b0; it.r = 0; it.c = 0; it.l = 1'b1;
    exp_q.push_back(it);
    in_valid = 1'b1; in_err = code; in_data = 12'h005;
    @(posedge clk); #1;
    in_valid = 1'b0; in_err = 2'b00; in_data = '0;
  endtask

  task automatic wait_drain();
    int done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every accepted element against the model, every stall for stability.
  initial begin
    item_t e, p, cur;
    logic stall;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        cur.d = out_data; cur.o = out_ovf; cur.r = int'(out_row); cur.c = int'(out_col); cur.l = out_last;
        if (stall) begin
          total++;
          if (!out_valid || cur.d != p.d || cur.o != p.o || cur.r != p.r || cur.c != p.c || cur.l != p.l) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b d=%h r=%0d c=%0d l=%0b expected v=1 d=%h r=%0d c=%0d l=%0b",
                     out_valid, cur.d, cur.r, cur.c, cur.l, p.d, p.r, p.c, p.l);
          end
        end
        stall = out_valid && !out_ready;
        p = cur;
        if (out_valid && out_ready) begin
          got_q.push_back(cur);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL drain_extra: got d=%h r=%0d c=%0d expected no element", cur.d, cur.r, cur.c);
          end else begin
            e = exp_q.pop_front();
            if (cur.d != e.d || cur.o != e.o || cur.r != e.r || cur.c != e.c || cur.l != e.l) begin
              bad++;
              $display("FAIL drain_elem: got d=%h o=%0b r=%0d c=%0d l=%0b expected d=%h o=%0b r=%0d c=%0d l=%0b",
                       cur.d, cur.o, cur.r, cur.c, cur.l, e.d, e.o, e.r, e.c, e.l);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0;
    in_last_col = 1'b0; in_last = 1'b0; in_err = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", {res_rows, res_cols, res_err, drop_err, out_last}, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2x2 frame, consumer always ready
    for (int i = 0; i < 4; i++) begin fvals[i] = 12'(i + 1); fovf[i] = 1'b0; end
    send_frame(4, 2);
    wait_drain();
    chk("r2x2_rows", res_rows, 2);
    chk("r2x2_cols", res_cols, 2);
    chk("r2x2_err", res_err, 0);
    chk("r2x2_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("r2x2_last_data", got_q[3].d, 4);
      chk("r2x2_last_flag", got_q[3].l, 1);
`ifdef MM_COLLECT_TRANSPOSE_EN
      chk("r2x2_second", got_q[1].d, 3);
`else
      chk("r2x2_second", got_q[1].d, 2);
`endif
    end

    // same frame, consumer toggling ready
    ready_mode = 1;
    send_frame(4, 2);
    wait_drain();
    ready_mode = 0;
    chk("toggle_count", got_q.size(), 4);

    // error marker frame
    send_err(2'b10);
    wait_drain();
    chk("err_res_err", res_err, 2);
    chk("err_res_rows", res_rows, 0);
    chk("err_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("err_elem", {got_q[0].d, got_q[0].l}, 1);

    // 17 elements into a 16-deep buffer
    for (int i = 0; i < 17; i++) begin fvals[i] = 12'(i * 100 - 800); fovf[i] = i[0]; end
    send_frame(17, 4);
    wait_drain();
    chk("full_drop_err", drop_err, 1);
    chk("full_rows", res_rows, exp_rows);
    chk("full_cols", res_cols, exp_cols);
    chk("full_count", got_q.size(), 16);

    // 1x1 frame with most-negative value and overflow flag
    fvals[0] = 12'h800; fovf[0] = 1'b1;
    send_frame(1, 1);
    wait_drain();
    chk("one_drop_clear", drop_err, 0);
    chk("one_rows", res_rows, 1);
    chk("one_cols", res_cols, 1);
    if (got_q.size() == 1) begin
      chk("one_data", got_q[0].d, 'h800);
      chk("one_ovf", got_q[0].o, 1);
    end else chk("one_count", got_q.size(), 1);

    // 2x3 frame 1..6
    for (int i = 0; i < 6; i++) begin fvals[i] = 12'(i + 1); fovf[i] = 1'b0; end
`ifdef MM_COLLECT_TRANSPOSE_EN
    lit6 = '{1, 4, 2, 5, 3, 6};
`else
    lit6 = '{1, 2, 3, 4, 5, 6};
`endif
    send_frame(6, 3);
    wait_drain();
    chk("r2x3_rows", res_rows, 2);
    chk("r2x3_cols", res_cols, 3);
    chk("r2x3_count", got_q.size(), 6);
    if (got_q.size() == 6)
      for (int i = 0; i < 6; i++) chk("r2x3_order", got_q[i].d, lit6[i]);

    // reset while the consumer stalls mid-drain
    ready_mode = 2;
    @(posedge clk); #1;
    send_frame(6, 3);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1; break; end
      end
      chk("midrst_valid_seen", seen, 1);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_rows", res_rows, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;

    // recovery frame after reset
    for (int i = 0; i < 4; i++) begin fvals[i] = 12'(12'hF00 + i); fovf[i] = 1'b0; end
    send_frame(4, 2);
    wait_drain();
    chk("recover_rows", res_rows, 2);
    chk("recover_count", got_q.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
